// File: rtl/karat_pkg.sv
// Shared width rules for the Karatsuba multiplier family.
// Later wide or recursive variants reuse these helpers so their widths stay consistent.
package karat_pkg;

    localparam int KARAT_DEF_WIDTH = 16;

    function automatic int karat_hw(input int width);
        return width / 2;
    endfunction

    // The sum of the two halves needs one carry bit.
    function automatic int karat_sum_w(input int hw);
        return hw + 1;
    endfunction

    function automatic int karat_prod_w(input int iw);
        return 2 * iw;
    endfunction

endpackage

// File: rtl/karat_half_mul.sv
// Combinational IW x IW -> 2*IW unsigned multiplier used for the Karatsuba sub-products.
// A recursive Karatsuba body can replace this module without changing its ports.
module karat_half_mul
    import karat_pkg::*;
#(
    parameter int IW = 8
) (
    input  logic [IW-1:0]               a_i,
    input  logic [IW-1:0]               b_i,
    output logic [karat_prod_w(IW)-1:0] p_o
);

    localparam int PW = karat_prod_w(IW);

    assign p_o = PW'(a_i) * PW'(b_i);

endmodule

// File: rtl/karat_pipe.sv
// Three-stage pipelined one-level Karatsuba multiplier with valid/ready back-pressure.
// Define KARAT_PIPE_SIGNED_EN to add the sgn port for two's-complement operands.
module karat_pipe
    import karat_pkg::*;
#(
    parameter int WIDTH = KARAT_DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef KARAT_PIPE_SIGNED_EN
    input  logic                 sgn,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   C
);

    localparam int H  = karat_hw(WIDTH);
    localparam int SW = karat_sum_w(H);
    localparam int PH = karat_prod_w(H);
    localparam int PM = karat_prod_w(SW);
    localparam int CW = 2 * WIDTH;

    logic adv;
    logic v1_q, v2_q, v3_q;

    // Stage 1: magnitudes, halves and half sums
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_d;
    logic [H-1:0]     al_d, ah_d, bl_d, bh_d;
    logic [SW-1:0]    sa_d, sb_d;
    logic [H-1:0]     al_q, ah_q, bl_q, bh_q;
    logic [SW-1:0]    sa_q, sb_q;
    logic             neg1_q, neg2_q;

`ifdef KARAT_PIPE_SIGNED_EN
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        a_mag = A;
        b_mag = B;
        neg_d = 1'b0;
        if (sgn) begin
            if (A[WIDTH-1]) a_mag = -A;
            if (B[WIDTH-1]) b_mag = -B;
            neg_d = A[WIDTH-1] ^ B[WIDTH-1];
        end
    end
`else
    assign a_mag = A;
    assign b_mag = B;
    assign neg_d = 1'b0;
`endif

    assign al_d = a_mag[H-1:0];
    assign ah_d = a_mag[WIDTH-1:H];
    assign bl_d = b_mag[H-1:0];
    assign bh_d = b_mag[WIDTH-1:H];
    assign sa_d = SW'(al_d) + SW'(ah_d);
    assign sb_d = SW'(bl_d) + SW'(bh_d);

    // Stage 2: the three sub-products
    logic [PH-1:0] p0_d, p2_d, p0_q, p2_q;
    logic [PM-1:0] pm_d, pm_q;

    karat_half_mul #(.IW(H))  u_p0 (.a_i(al_q), .b_i(bl_q), .p_o(p0_d));
    karat_half_mul #(.IW(H))  u_p2 (.a_i(ah_q), .b_i(bh_q), .p_o(p2_d));
    karat_half_mul #(.IW(SW)) u_pm (.a_i(sa_q), .b_i(sb_q), .p_o(pm_d));

    // Stage 3: recombine; modulo-2^CW arithmetic equals truncating the wider exact sum.
    logic [PM-1:0] mid;
    logic [CW-1:0] prod, c_d, c_q;

    assign mid  = pm_q - PM'(p0_q) - PM'(p2_q);
    assign prod = (CW'(p2_q) << WIDTH) + (CW'(mid) << H) + CW'(p0_q);
    assign c_d  = neg2_q ? -prod : prod;

    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign C         = c_q;

    always_ff @(posedge clk) begin
        // NOTE: only control state and the visible result are reset; datapath registers are qualified by their valids.
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            c_q  <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) c_q <= c_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            al_q   <= al_d;
            ah_q   <= ah_d;
            bl_q   <= bl_d;
            bh_q   <= bh_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            neg1_q <= neg_d;
        end
        if (adv && v1_q) begin
            p0_q   <= p0_d;
            p2_q   <= p2_d;
            pm_q   <= pm_d;
            neg2_q <= neg1_q;
        end
    end

endmodule

// File: tb/tb_karat_pipe.sv
// Self-checking bench for karat_pipe: 16-bit and 32-bit instances against a plain A*B model.
// Signed scenarios run when KARAT_PIPE_SIGNED_EN is defined.
module tb_karat_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1, sgn16 = 1'b0;
    logic        in_ready16, out_valid16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] c16;

    logic        in_valid32 = 1'b0, out_ready32 = 1'b1, sgn32 = 1'b0;
    logic        in_ready32, out_valid32;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] c32;

    int errors = 0;
    int checks = 0;
    logic [31:0] q16[$];

    karat_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst),
`ifdef KARAT_PIPE_SIGNED_EN
        .sgn(sgn16),
`endif
        .in_valid(in_valid16), .in_ready(in_ready16), .A(a16), .B(b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .C(c16)
    );

    karat_pipe #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst),
`ifdef KARAT_PIPE_SIGNED_EN
        .sgn(sgn32),
`endif
        .in_valid(in_valid32), .in_ready(in_ready32), .A(a32), .B(b32),
        .out_valid(out_valid32), .out_ready(out_ready32), .C(c32)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int sa, sb;
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return 32'(sa * sb);
        end
        return 32'(a) * 32'(b);
    endfunction

    // Single operand pair with exact latency check: out_valid must appear on the third edge only.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [31:0] exp, input string name);
        in_valid16 = 1'b1; a16 = a; b16 = b; sgn16 = s; out_ready16 = 1'b1;
        #1;
        checks++;
        if (in_ready16 !== 1'b1) begin
            errors++; $display("FAIL %s in_ready: got %b want 1", name, in_ready16);
        end
        tick;
        in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) tick;
            checks++;
            if (k < 3) begin
                if (out_valid16 !== 1'b0) begin
                    errors++; $display("FAIL %s early out_valid at edge %0d", name, k);
                end
            end else if (out_valid16 !== 1'b1 || c16 !== exp) begin
                errors++;
                $display("FAIL %s: out_valid=%b C=%h want out_valid=1 C=%h", name, out_valid16, c16, exp);
            end
        end
        tick;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input string name);
        in_valid32 = 1'b1; a32 = a; b32 = b; out_ready32 = 1'b1;
        tick;
        in_valid32 = 1'b0;
        tick; tick;
        checks++;
        if (out_valid32 !== 1'b1 || c32 !== exp) begin
            errors++;
            $display("FAIL %s: out_valid=%b C=%h want out_valid=1 C=%h", name, out_valid32, c32, exp);
        end
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        checks++;
        if (out_valid16 !== 1'b0 || c16 !== 32'h0 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL reset16: out_valid=%b C=%h in_ready=%b want 0/0/1", out_valid16, c16, in_ready16);
        end
        checks++;
        if (out_valid32 !== 1'b0 || c32 !== 64'h0 || in_ready32 !== 1'b1) begin
            errors++;
            $display("FAIL reset32: out_valid=%b C=%h in_ready=%b want 0/0/1", out_valid32, c32, in_ready32);
        end
    endtask

    task automatic test_directed;
        send16(16'h1234, 16'h5678, 1'b0, 32'h0626_0060, "dir_1234x5678");
        send16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "dir_ffffxffff");
        send16(16'h0000, 16'hBEEF, 1'b0, 32'h0000_0000, "dir_zero");
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom); b = 16'($urandom);
            send16(a, b, 1'b0, model16(a, b, 1'b0), "dir_random");
        end
    endtask

    task automatic test_back_to_back;
        int got = 0, first = -1, last = -1;
        q16.delete();
        out_ready16 = 1'b1; sgn16 = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid16 = (cyc < 8);
            a16 = 16'($urandom); b16 = 16'($urandom);
            #1;
            if (out_valid16 && out_ready16) begin
                got++;
                if (first < 0) first = cyc;
                last = cyc;
                checks++;
                if (q16.size() == 0 || c16 !== q16[0]) begin
                    errors++; $display("FAIL b2b product: C=%h want %h", c16, (q16.size() != 0) ? q16[0] : 32'h0);
                end
                if (q16.size() != 0) void'(q16.pop_front());
            end
            if (in_valid16 && in_ready16) q16.push_back(model16(a16, b16, 1'b0));
            tick;
        end
        checks++;
        if (got != 8 || last - first != 7 || q16.size() != 0) begin
            errors++;
            $display("FAIL b2b stream: got=%0d span=%0d left=%0d want 8/7/0", got, last - first, q16.size());
        end
    endtask

    task automatic test_backpressure;
        int acc = 0, got = 0;
        logic [31:0] held = '0;
        q16.delete();
        sgn16 = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready16 = !(cyc >= 3 && cyc < 8);
            in_valid16  = (cyc < 12);
            a16 = 16'($urandom); b16 = 16'($urandom);
            #1;
            if (cyc == 3) held = c16;
            if (cyc >= 3 && cyc < 8) begin
                checks++;
                if (in_ready16 !== 1'b0 || out_valid16 !== 1'b1 || c16 !== held) begin
                    errors++;
                    $display("FAIL stall cyc%0d: in_ready=%b out_valid=%b C=%h want 0/1/%h",
                             cyc, in_ready16, out_valid16, c16, held);
                end
            end
            if (out_valid16 && out_ready16) begin
                got++;
                checks++;
                if (q16.size() == 0 || c16 !== q16[0]) begin
                    errors++; $display("FAIL bp product: C=%h want %h", c16, (q16.size() != 0) ? q16[0] : 32'h0);
                end
                if (q16.size() != 0) void'(q16.pop_front());
            end
            if (in_valid16 && in_ready16) begin
                acc++;
                q16.push_back(model16(a16, b16, 1'b0));
            end
            tick;
        end
        out_ready16 = 1'b1;
        checks++;
        if (acc != 7 || got != 7 || q16.size() != 0) begin
            errors++; $display("FAIL bp count: accepted=%0d emitted=%0d want 7/7", acc, got);
        end
    endtask

    task automatic test_reset_midstream;
        logic [15:0] a, b;
        out_ready16 = 1'b1; sgn16 = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            in_valid16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
            tick;
        end
        in_valid16 = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL midreset: out_valid=%b in_ready=%b want 0/1", out_valid16, in_ready16);
        end
        a = 16'($urandom); b = 16'($urandom);
        send16(a, b, 1'b0, model16(a, b, 1'b0), "after_reset");
    endtask

    task automatic test_width32;
        logic [31:0] a, b;
        send32(32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, "w32_max_x2");
        send32(32'h0, 32'($urandom), 64'h0, "w32_zero");
        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "w32_max_sq");
        for (int i = 0; i < 3; i++) begin
            a = 32'($urandom); b = 32'($urandom);
            send32(a, b, 64'(a) * 64'(b), "w32_random");
        end
    endtask

`ifdef KARAT_PIPE_SIGNED_EN
    task automatic test_signed;
        logic [15:0] a, b;
        send16(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, "sgn_m1xm1");
        send16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "sgn_minxmin");
        send16(16'h8000, 16'h8000, 1'b0, 32'h4000_0000, "uns_8000x8000");
        send16(16'hFFFE, 16'h0003, 1'b1, 32'hFFFF_FFFA, "sgn_m2x3");
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            send16(a, b, 1'b1, model16(a, b, 1'b1), "sgn_random");
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_backpressure;
        test_reset_midstream;
        test_width32;
`ifdef KARAT_PIPE_SIGNED_EN
        test_signed;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/karat_pipe.md
Name: karat_pipe

Overview:
- Parametrised, pipelined Karatsuba multiplier: one-level Karatsuba split of WIDTH-bit operands into halves, three half-width sub-products, recombination.
- Successor to the fixed 16x16 combinational multiplier. Adds operand width as a parameter, a 3-stage registered pipeline and a valid/ready handshake with back-pressure.
- Sits between the operand source and any downstream consumer that may stall.

Parameters:
- WIDTH, 16, operand width in bits. Even, minimum 8. Product is 2*WIDTH bits.
- H, WIDTH/2, half width. Derived localparam, not overridable.

Ports:
- clk        input   1          rising-edge clock
- rst        input   1          synchronous, active-high reset
- in_valid   input   1          operand pair valid
- in_ready   output  1          block can accept operands this cycle
- A          input   WIDTH      multiplicand
- B          input   WIDTH      multiplier
- out_valid  output  1          C holds a valid product
- out_ready  input   1          consumer accepts C this cycle
- C          output  2*WIDTH    product A*B

Behaviour:
- Reset: sampled on the clk edge. Clears v1, v2, v3 (stage valids); out_valid=0, C=0, in_ready=1 on the cycle after reset. Reset mid-operation discards all in-flight products without emitting them.
- Stage 1 (split/sum):
  - al=A[H-1:0], ah=A[WIDTH-1:H], bl, bh likewise.
  - sa=al+ah and sb=bl+bh, each H+1 bits, no truncation.
  - Registers al, ah, bl, bh, sa, sb.
- Stage 2 (products):
  - p0=al*bl (2H bits), p2=ah*bh (2H bits), pm=sa*sb (2H+2 bits).
  - Each product comes from one karat_half_mul instance. Registers p0, p2, pm.
- Stage 3 (combine):
  - mid=pm-p0-p2, 2H+2 bits, never negative.
  - C=(p2<<WIDTH)+(mid<<H)+p0, computed at 2*WIDTH+2 bits and truncated to 2*WIDTH. Truncation is lossless.
  - Registered into C, out_valid=v3.
- Latency: exactly 3 cycles from the input handshake (in_valid&&in_ready) to out_valid, when out_ready is held high.
- Throughput: one product per cycle.
- Advance: adv = !v3 || out_ready. in_ready = adv (combinational).
  - When adv=1, all stages shift: v1<=in_valid, v2<=v1, v3<=v2.
  - When adv=0, every stage register and C hold their values.
- Output rules:
  - C and out_valid are stable while out_valid=1 and out_ready=0.
  - C is don't-care when out_valid=0, but the implementation must not toggle C unless adv=1.
- Bubbles propagate as v=0. out_ready may be high with out_valid low (no effect).
- Simultaneous output accept and input accept in the same cycle is legal and required for full throughput.
- No combinational path from in_valid, A or B to any output.

Optional Feature:
- Macro KARAT_PIPE_SIGNED_EN.
- Defined:
  - Extra input port sgn (1 bit), captured with A/B at the input handshake and carried down the pipe.
  - sgn=1: A and B are two's complement. Stage 1 takes magnitudes; a result sign bit (A msb XOR B msb) travels down the pipe. Stage 3 negates the unsigned product when the sign bit is 1.
  - sgn=0: behaviour is identical to the unsigned build.
  - Latency unchanged.
- Undefined: no sgn port; operands are always unsigned.

Decomposition:
- Package karat_pkg holds:
  - function karat_hw(width) returning the half width
  - localparam defaults (KARAT_DEF_WIDTH=16)
  - product-width helper functions, so later wider/recursive variants share the same width rules.
- One sub-module, karat_half_mul:
  - parameter IW
  - combinational IW x IW -> 2*IW multiplier
  - instantiated three times, with IW=H for p0 and p2 and IW=H+1 for pm.
- A recursive Karatsuba generation can replace karat_half_mul's body without touching karat_pipe.

Test Plan:
- WIDTH=16, out_ready=1: A=0x1234, B=0x5678 -> C=0x06260060 with out_valid exactly 3 cycles after the handshake. A=0xFFFF, B=0xFFFF -> C=0xFFFE0001 (maximum carry in sa/sb/mid).
- Back-to-back stream of 8 random pairs with out_ready=1 -> 8 consecutive out_valid cycles, products match the reference A*B in order.
- Back-pressure: fill the pipe, drop out_ready for 5 cycles -> in_ready=0, C/out_valid frozen. Release -> no product lost or duplicated.
- Reset mid-stream: assert rst with 3 products in flight -> next cycle out_valid=0, in_ready=1. A new operand pair produces the correct result 3 cycles later.
- WIDTH=32 build: A=0xFFFFFFFF, B=0x00000002 -> C=0x00000001FFFFFFFE; A=0, B=any -> C=0.
- KARAT_PIPE_SIGNED_EN, WIDTH=16:
  - sgn=1, A=0xFFFF, B=0xFFFF -> C=0x00000001
  - sgn=1, A=0x8000, B=0x8000 -> C=0x40000000
  - sgn=0, same A/B -> C=0x40000000
  - sgn=1, A=0xFFFE, B=0x0003 -> C=0xFFFFFFFA
